// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, access
// opcodes, interrupt cause codes and trap FSM states.
package csr_pkg;

   localparam logic [11:0] AddrMstatus   = 12'h300;
   localparam logic [11:0] AddrMie       = 12'h304;
   localparam logic [11:0] AddrMtvec     = 12'h305;
   localparam logic [11:0] AddrMepc      = 12'h341;
   localparam logic [11:0] AddrMcause    = 12'h342;
   localparam logic [11:0] AddrMip       = 12'h344;
   localparam logic [11:0] AddrMcycle    = 12'hB00;
   localparam logic [11:0] AddrMtime     = 12'hB01;
   localparam logic [11:0] AddrMinstret  = 12'hB02;
   localparam logic [11:0] AddrMtimecmp  = 12'hB03;
   localparam logic [11:0] AddrMcycleh   = 12'hB80;
   localparam logic [11:0] AddrMtimeh    = 12'hB81;
   localparam logic [11:0] AddrMinstreth = 12'hB82;
   localparam logic [11:0] AddrMtimecmph = 12'hB83;

   typedef enum logic [1:0] {
      OpRead  = 2'b00,
      OpWrite = 2'b01,
      OpSet   = 2'b10,
      OpClear = 2'b11
   } csr_op_e;

   localparam logic [4:0] CauseTimer   = 5'd7;
   localparam logic [4:0] CauseExtBase = 5'd16;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StHandler
   } trap_st_e;

endpackage

// File: rtl/csr_counter.sv
// Free-running CNT_W-bit counter with enable and synchronous reset; exposes
// the value as 32-bit lo/hi halves (hi reads 0 when CNT_W is 32).
module csr_counter #(
   parameter int unsigned CNT_W = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             hi_sel_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [31:0]      rdata_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      cnt_ext;

   assign cnt_d = en_i ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Zero-extend so a 32-bit counter naturally reads 0 in its hi half.
   assign cnt_ext = 64'(cnt_q);
   assign rdata_o = hi_sel_i ? cnt_ext[63:32] : cnt_ext[31:0];
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR file with interrupt trap FSM and machine timer.
// Optional CSR_VECTORED_EN enables mtvec MODE=1 (vectored interrupt targets).
module csr_file_m
   import csr_pkg::*;
#(
   parameter int unsigned NUM_IRQ   = 3,
   parameter int unsigned CNT_W     = 64,
   parameter int unsigned TIMER_DIV = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               csr_en_i,
   input  logic [1:0]         csr_op_i,
   input  logic [11:0]        csr_addr_i,
   input  logic [31:0]        csr_wdata_i,
   output logic [31:0]        csr_rdata_o,
   output logic               csr_illegal_o,
   input  logic               retire_i,
   input  logic [NUM_IRQ-1:0] irq_in_i,
   input  logic [31:0]        trap_pc_i,
   input  logic               trap_ack_i,
   input  logic               mret_i,
   output logic               irq_req_o,
   output logic [31:0]        trap_target_o,
   output logic [31:0]        mepc_out_o
);

   localparam logic [31:0] MieMask = 32'h0000_0080 | (((32'h1 << NUM_IRQ) - 32'h1) << 16);

   csr_op_e          op;
   logic [31:0]      old_val, wval, mip, pend;
   logic             known, read_only, wr_en, trap_fire, mtip, tick, take_irq;
   logic [31:0]      pre_q;
   logic [CNT_W-1:0] cyc_full, ret_full, mtime;
   logic [31:0]      cyc_rdata, ret_rdata, time_rdata;
   logic             unused_cnt;

   logic             mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
   logic [31:0]      mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic [63:0]      cmp_q, cmp_d;

   trap_st_e         state_q;
   logic [4:0]       cause_q, win_cause;
   logic             irq_req_q;

   // mtime prescaler
   assign tick = (pre_q == 32'(TIMER_DIV - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_q <= '0;
      end else begin
         pre_q <= tick ? '0 : pre_q + 32'd1;
      end
   end

   csr_counter #(.CNT_W(CNT_W)) u_mcycle (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (1'b1),
      .hi_sel_i (csr_addr_i[7]),
      .cnt_o    (cyc_full),
      .rdata_o  (cyc_rdata)
   );

   csr_counter #(.CNT_W(CNT_W)) u_minstret (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (retire_i),
      .hi_sel_i (csr_addr_i[7]),
      .cnt_o    (ret_full),
      .rdata_o  (ret_rdata)
   );

   csr_counter #(.CNT_W(CNT_W)) u_mtime (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (tick),
      .hi_sel_i (csr_addr_i[7]),
      .cnt_o    (mtime),
      .rdata_o  (time_rdata)
   );

   assign unused_cnt = ^{cyc_full, ret_full};

   assign mtip = (mtime >= cmp_q[CNT_W-1:0]);

   always_comb begin
      mip = '0;
      mip[7] = mtip;
      mip[16 +: NUM_IRQ] = irq_in_i;
   end

   assign pend     = mie_q & mip;
   assign take_irq = mst_mie_q & (|pend);

   // Lowest external index wins; the timer only when no external is pending.
   always_comb begin
      win_cause = CauseTimer;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (pend[16 + i]) win_cause = CauseExtBase + 5'(i);
      end
   end

   always_comb begin
      old_val   = '0;
      known     = 1'b1;
      read_only = 1'b0;
      case (csr_addr_i)
         AddrMstatus:   old_val = {24'b0, mst_mpie_q, 3'b0, mst_mie_q, 3'b0};
         AddrMie:       old_val = mie_q;
         AddrMtvec:     old_val = mtvec_q;
         AddrMepc:      old_val = mepc_q;
         AddrMcause:    old_val = mcause_q;
         AddrMip: begin
            old_val   = mip;
            read_only = 1'b1;
         end
         AddrMcycle, AddrMcycleh: begin
            old_val   = cyc_rdata;
            read_only = 1'b1;
         end
         AddrMtime, AddrMtimeh: begin
            old_val   = time_rdata;
            read_only = 1'b1;
         end
         AddrMinstret, AddrMinstreth: begin
            old_val   = ret_rdata;
            read_only = 1'b1;
         end
         AddrMtimecmp:  old_val = cmp_q[31:0];
         AddrMtimecmph: old_val = (CNT_W > 32) ? cmp_q[63:32] : 32'h0;
         default:       known = 1'b0;
      endcase
   end

   assign op            = csr_op_e'(csr_op_i);
   assign csr_rdata_o   = old_val;
   assign csr_illegal_o = csr_en_i & (~known | (read_only & (op != OpRead)));
   assign trap_fire     = (state_q == StReq) & trap_ack_i;
   assign wr_en         = csr_en_i & ~csr_illegal_o & (op != OpRead) & ~trap_fire;

   always_comb begin
      case (op)
         OpWrite: wval = csr_wdata_i;
         OpSet:   wval = old_val | csr_wdata_i;
         OpClear: wval = old_val & ~csr_wdata_i;
         default: wval = old_val;
      endcase
   end

   // Priority: CSR write, then mret stacking, then trap entry (which drops the write).
   always_comb begin
      mst_mie_d  = mst_mie_q;
      mst_mpie_d = mst_mpie_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      cmp_d      = cmp_q;
      if (wr_en) begin
         case (csr_addr_i)
            AddrMstatus: begin
               mst_mie_d  = wval[3];
               mst_mpie_d = wval[7];
            end
            AddrMie:       mie_d = wval & MieMask;
`ifdef CSR_VECTORED_EN
            AddrMtvec:     mtvec_d = {wval[31:2], 1'b0, wval[1] ? mtvec_q[0] : wval[0]};
`else
            AddrMtvec:     mtvec_d = {wval[31:2], 2'b00};
`endif
            AddrMepc:      mepc_d = {wval[31:2], 2'b00};
            AddrMcause:    mcause_d = wval;
            AddrMtimecmp:  cmp_d[31:0] = wval;
            AddrMtimecmph: if (CNT_W > 32) cmp_d[63:32] = wval;
            default: ;
         endcase
      end
      if (mret_i) begin
         mst_mie_d  = mst_mpie_q;
         mst_mpie_d = 1'b1;
      end
      if (trap_fire) begin
         mepc_d     = trap_pc_i & 32'hFFFF_FFFC;
         mcause_d   = {1'b1, 26'b0, cause_q};
         mst_mpie_d = mst_mie_q;
         mst_mie_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         cmp_q      <= '1;
      end else begin
         mst_mie_q  <= mst_mie_d;
         mst_mpie_q <= mst_mpie_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         cmp_q      <= cmp_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cause_q   <= '0;
         irq_req_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (take_irq) begin
                  state_q   <= StReq;
                  cause_q   <= win_cause;
                  irq_req_q <= 1'b1;
               end
            end
            StReq: begin
               if (trap_ack_i) begin
                  state_q   <= StHandler;
                  irq_req_q <= 1'b0;
               end
            end
            StHandler: begin
               if (mret_i) state_q <= StIdle;
            end
            default: begin
               state_q   <= StIdle;
               irq_req_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef CSR_VECTORED_EN
   assign trap_target_o = mtvec_q[0] ? {mtvec_q[31:2], 2'b00} + {25'b0, cause_q, 2'b00}
                                     : {mtvec_q[31:2], 2'b00};
`else
   assign trap_target_o = {mtvec_q[31:2], 2'b00};
`endif

   assign irq_req_o  = irq_req_q;
   assign mepc_out_o = mepc_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Directed self-checking bench for csr_file_m (default parameters).
`timescale 1ns/1ps
module tb_csr_file_m;

   logic        clk = 1'b0;
   logic        rst, csr_en, retire, trap_ack, mret;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, trap_pc;
   logic [2:0]  irq_in;
   logic [31:0] csr_rdata, trap_target, mepc_out;
   logic        csr_illegal, irq_req;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   csr_file_m dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .csr_en_i      (csr_en),
      .csr_op_i      (csr_op),
      .csr_addr_i    (csr_addr),
      .csr_wdata_i   (csr_wdata),
      .csr_rdata_o   (csr_rdata),
      .csr_illegal_o (csr_illegal),
      .retire_i      (retire),
      .irq_in_i      (irq_in),
      .trap_pc_i     (trap_pc),
      .trap_ack_i    (trap_ack),
      .mret_i        (mret),
      .irq_req_o     (irq_req),
      .trap_target_o (trap_target),
      .mepc_out_o    (mepc_out)
   );

   // One CSR access: drive, sample the combinational result, then clock it in.
   task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic ill);
      csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
      #1;
      rd  = csr_rdata;
      ill = csr_illegal;
      @(posedge clk); #1;
      csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_mret();
      mret = 1'b1; cycles(1); mret = 1'b0;
   endtask

   task automatic pulse_ack(input logic [31:0] pc);
      trap_pc = pc; trap_ack = 1'b1; cycles(1); trap_ack = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic ill;
      rst = 1'b1; cycles(3); rst = 1'b0;
      csr(2'b00, 12'hB00, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h0) $display("FAIL reset_mcycle got %h want 0", rd); else pass_cnt++;
      total_cnt++; if (ill !== 1'b0) $display("FAIL reset_ill got %b want 0", ill); else pass_cnt++;
      csr(2'b00, 12'hB00, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h1) $display("FAIL mcycle_inc got %h want 1", rd); else pass_cnt++;
      csr(2'b00, 12'h300, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h0) $display("FAIL reset_mstatus got %h want 0", rd); else pass_cnt++;
      csr(2'b00, 12'h304, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h0) $display("FAIL reset_mie got %h want 0", rd); else pass_cnt++;
      csr(2'b00, 12'hB03, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'hFFFF_FFFF) $display("FAIL reset_cmp_lo got %h want ffffffff", rd); else pass_cnt++;
      csr(2'b00, 12'hB83, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'hFFFF_FFFF) $display("FAIL reset_cmp_hi got %h want ffffffff", rd); else pass_cnt++;
      total_cnt++; if (irq_req !== 1'b0) $display("FAIL reset_irq_req got %b want 0", irq_req); else pass_cnt++;
      total_cnt++; if (trap_target !== 32'h0) $display("FAIL reset_target got %h want 0", trap_target); else pass_cnt++;
   endtask

   task automatic test_ext_irq();
      logic [31:0] rd; logic ill;
      csr(2'b01, 12'h305, 32'h100, rd, ill);
      csr(2'b10, 12'h300, 32'h8, rd, ill);
      csr(2'b01, 12'h304, 32'h1_0000, rd, ill);
      irq_in = 3'b001;
      total_cnt++; if (irq_req !== 1'b0) $display("FAIL ext_req_early got %b want 0", irq_req); else pass_cnt++;
      cycles(1);
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL ext_req_raise got %b want 1", irq_req); else pass_cnt++;
      total_cnt++; if (trap_target !== 32'h100) $display("FAIL ext_target got %h want 100", trap_target); else pass_cnt++;
      irq_in = 3'b000;
      cycles(1);
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL ext_req_held got %b want 1", irq_req); else pass_cnt++;
      pulse_ack(32'h40);
      total_cnt++; if (irq_req !== 1'b0) $display("FAIL ext_req_ack got %b want 0", irq_req); else pass_cnt++;
      total_cnt++; if (mepc_out !== 32'h40) $display("FAIL ext_mepc got %h want 40", mepc_out); else pass_cnt++;
      csr(2'b00, 12'h342, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h8000_0010) $display("FAIL ext_mcause got %h want 80000010", rd); else pass_cnt++;
      csr(2'b00, 12'h300, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h80) $display("FAIL ext_mstatus got %h want 80", rd); else pass_cnt++;
      pulse_mret();
      csr(2'b00, 12'h300, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h88) $display("FAIL ext_mret_mstatus got %h want 88", rd); else pass_cnt++;
   endtask

   task automatic test_timer();
      logic [31:0] rd; logic ill;
      csr(2'b01, 12'h304, 32'h80, rd, ill);
      csr(2'b01, 12'hB03, 32'd20, rd, ill);
      csr(2'b01, 12'hB83, 32'h0, rd, ill);
      for (int i = 0; i < 400 && irq_req !== 1'b1; i++) cycles(1);
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL timer_req got %b want 1 (timeout)", irq_req); else pass_cnt++;
      csr(2'b00, 12'hB01, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'd20) $display("FAIL timer_mtime got %0d want 20", rd); else pass_cnt++;
      csr(2'b00, 12'h344, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h80) $display("FAIL timer_mip got %h want 80", rd); else pass_cnt++;
      csr(2'b01, 12'hB03, 32'd100, rd, ill);
      csr(2'b00, 12'h344, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h0) $display("FAIL timer_mip_clr got %h want 0", rd); else pass_cnt++;
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL timer_req_held got %b want 1", irq_req); else pass_cnt++;
      pulse_ack(32'h80);
      csr(2'b00, 12'h342, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h8000_0007) $display("FAIL timer_mcause got %h want 80000007", rd); else pass_cnt++;
      pulse_mret();
   endtask

   task automatic test_illegal();
      logic [31:0] rd, c1; logic ill;
      csr(2'b00, 12'hB00, 32'h0, c1, ill);
      csr(2'b01, 12'hB00, 32'h0, rd, ill);
      total_cnt++; if (ill !== 1'b1) $display("FAIL ill_mcycle_wr got %b want 1", ill); else pass_cnt++;
      csr(2'b00, 12'hB00, 32'h0, rd, ill);
      total_cnt++; if (rd !== c1 + 32'd2) $display("FAIL ill_mcycle_runs got %0d want %0d", rd, c1 + 32'd2); else pass_cnt++;
      csr(2'b10, 12'h344, 32'h80, rd, ill);
      total_cnt++; if (ill !== 1'b1) $display("FAIL ill_mip_wr got %b want 1", ill); else pass_cnt++;
      csr(2'b00, 12'h123, 32'h0, rd, ill);
      total_cnt++; if (ill !== 1'b1 || rd !== 32'h0) $display("FAIL ill_unknown got %b/%h want 1/0", ill, rd); else pass_cnt++;
      csr(2'b01, 12'h304, 32'h7_0080, rd, ill);
      total_cnt++; if (ill !== 1'b0) $display("FAIL ill_mie_wr got %b want 0", ill); else pass_cnt++;
      csr(2'b11, 12'h304, 32'h80, rd, ill);
      csr(2'b00, 12'h304, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h7_0000) $display("FAIL mie_clear got %h want 70000", rd); else pass_cnt++;
   endtask

   task automatic test_priority();
      logic [31:0] rd; logic ill;
      csr(2'b11, 12'h300, 32'h8, rd, ill);
      csr(2'b01, 12'h304, 32'h5_0080, rd, ill);
      csr(2'b01, 12'hB03, 32'h0, rd, ill);
      irq_in = 3'b101;
      csr(2'b10, 12'h300, 32'h8, rd, ill);
      cycles(1);
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL prio_req got %b want 1", irq_req); else pass_cnt++;
      pulse_ack(32'h200);
      csr(2'b00, 12'h342, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h8000_0010) $display("FAIL prio_first got %h want 80000010", rd); else pass_cnt++;
      irq_in = 3'b100;
      pulse_mret();
      csr(2'b00, 12'h300, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h88) $display("FAIL prio_mret got %h want 88", rd); else pass_cnt++;
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL prio_req2 got %b want 1", irq_req); else pass_cnt++;
      pulse_ack(32'h204);
      csr(2'b00, 12'h342, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h8000_0012) $display("FAIL prio_second got %h want 80000012", rd); else pass_cnt++;
   endtask

   task automatic test_vectored();
      logic [31:0] rd, exp_tvec, exp_tgt; logic ill;
`ifdef CSR_VECTORED_EN
      exp_tvec = 32'h101; exp_tgt = 32'h11C;
`else
      exp_tvec = 32'h100; exp_tgt = 32'h100;
`endif
      irq_in = 3'b000;
      csr(2'b01, 12'h305, 32'h101, rd, ill);
      csr(2'b00, 12'h305, 32'h0, rd, ill);
      total_cnt++; if (rd !== exp_tvec) $display("FAIL vec_mtvec got %h want %h", rd, exp_tvec); else pass_cnt++;
      pulse_mret();
      cycles(1);
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL vec_req got %b want 1", irq_req); else pass_cnt++;
      total_cnt++; if (trap_target !== exp_tgt) $display("FAIL vec_target got %h want %h", trap_target, exp_tgt); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic ill;
      csr(2'b11, 12'h300, 32'h8, rd, ill);
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL b2b_req_mie_clr got %b want 1", irq_req); else pass_cnt++;
      trap_pc = 32'h300; trap_ack = 1'b1;
      csr(2'b01, 12'h304, 32'h0, rd, ill);
      trap_ack = 1'b0;
      csr(2'b00, 12'h304, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h5_0080) $display("FAIL b2b_wr_dropped got %h want 50080", rd); else pass_cnt++;
      csr(2'b00, 12'h342, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h8000_0007) $display("FAIL b2b_mcause got %h want 80000007", rd); else pass_cnt++;
      total_cnt++; if (mepc_out !== 32'h300) $display("FAIL b2b_mepc got %h want 300", mepc_out); else pass_cnt++;
      csr(2'b00, 12'h300, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h0) $display("FAIL b2b_mstatus got %h want 0", rd); else pass_cnt++;
      pulse_mret();
      cycles(2);
      total_cnt++; if (irq_req !== 1'b0) $display("FAIL b2b_no_req got %b want 0", irq_req); else pass_cnt++;
      csr(2'b00, 12'h300, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h80) $display("FAIL b2b_mret_mstatus got %h want 80", rd); else pass_cnt++;
      // mret outside HANDLER: stack restored, FSM untouched
      pulse_mret();
      cycles(1);
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL idle_mret_req got %b want 1", irq_req); else pass_cnt++;
      pulse_mret();
      total_cnt++; if (irq_req !== 1'b1) $display("FAIL req_mret_keeps got %b want 1", irq_req); else pass_cnt++;
      csr(2'b00, 12'h300, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h88) $display("FAIL req_mret_mstatus got %h want 88", rd); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic ill;
      rst = 1'b1; cycles(1); rst = 1'b0;
      total_cnt++; if (irq_req !== 1'b0) $display("FAIL rst_mid_req got %b want 0", irq_req); else pass_cnt++;
      csr(2'b00, 12'h300, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h0) $display("FAIL rst_mid_mstatus got %h want 0", rd); else pass_cnt++;
      csr(2'b00, 12'hB03, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rst_mid_cmp got %h want ffffffff", rd); else pass_cnt++;
      retire = 1'b1; cycles(3); retire = 1'b0;
      csr(2'b00, 12'hB02, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'd3) $display("FAIL minstret got %0d want 3", rd); else pass_cnt++;
      csr(2'b00, 12'hB82, 32'h0, rd, ill);
      total_cnt++; if (rd !== 32'h0) $display("FAIL minstreth got %h want 0", rd); else pass_cnt++;
      csr(2'b10, 12'hB02, 32'h1, rd, ill);
      total_cnt++; if (ill !== 1'b1) $display("FAIL ill_minstret_wr got %b want 1", ill); else pass_cnt++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
      retire = 1'b0; irq_in = 3'b000; trap_pc = 32'h0; trap_ack = 1'b0; mret = 1'b0;
      test_reset();
      test_ext_irq();
      test_timer();
      test_illegal();
      test_priority();
      test_vectored();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
